// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: waits for a filtered PLL lock, enables clocks, then releases
// NUM_STAGES downstream reset domains one at a time, STAGE_DELAY clocks apart.
module reset_seq_ctrl #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 16,
  parameter int LOCK_FILTER = 8
) (
  input  logic                  clk_p,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  output logic                  clk_en,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  seq_done,
  output logic [7:0]            lock_loss_cnt,
  output logic [2:0]            state_o
);

  localparam int LW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int DW = $clog2(STAGE_DELAY);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_CLK_EN    = 3'd1;
  localparam logic [2:0] S_RELEASE   = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_SOFT      = 3'd4;

  logic rst_meta_q, rst_sync_q;
  logic lock_meta_q, locked_q;

  logic [2:0]            state_q, state_d;
  logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
  logic [DW-1:0]         dly_cnt_q, dly_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  clk_en_q, clk_en_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic [7:0]            loss_q, loss_d;

  // Reset asserts immediately but is released only after two clean edges.
  always_ff @(posedge clk_p or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  always_ff @(posedge clk_p or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      locked_q    <= lock_meta_q;
    end
  end

  always_comb begin
    // NOTE: every _d starts at its held value so no path through the case can infer a latch.
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    idx_d      = idx_q;
    clk_en_d   = clk_en_q;
    rst_n_d    = rst_n_q;
    done_d     = done_q;
    loss_d     = loss_q;

    if (state_q != S_WAIT_LOCK && !locked_q && state_q <= S_SOFT) begin
      // Lock loss outranks any soft request arriving on the same edge.
      state_d    = S_WAIT_LOCK;
      clk_en_d   = 1'b0;
      rst_n_d    = '0;
      done_d     = 1'b0;
      lock_cnt_d = '0;
      dly_cnt_d  = '0;
      idx_d      = '0;
      if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (!locked_q) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_d    = S_CLK_EN;
            clk_en_d   = 1'b1;
            lock_cnt_d = '0;
            dly_cnt_d  = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        S_CLK_EN: begin
          if (dly_cnt_q == DLY_LAST) begin
            state_d   = S_RELEASE;
            dly_cnt_d = '0;
            idx_d     = '0;
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (soft_rst_req) begin
            state_d   = S_SOFT;
            rst_n_d   = '0;
            done_d    = 1'b0;
            dly_cnt_d = '0;
            idx_d     = '0;
          end else if (dly_cnt_q == DLY_LAST) begin
            dly_cnt_d      = '0;
            rst_n_d[idx_q] = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (soft_rst_req) begin
            state_d   = S_SOFT;
            rst_n_d   = '0;
            done_d    = 1'b0;
            dly_cnt_d = '0;
            idx_d     = '0;
          end
        end
        S_SOFT: begin
          if (dly_cnt_q == DLY_LAST) begin
            state_d   = S_RELEASE;
            dly_cnt_d = '0;
            idx_d     = '0;
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = S_WAIT_LOCK;
          clk_en_d   = 1'b0;
          rst_n_d    = '0;
          done_d     = 1'b0;
          lock_cnt_d = '0;
          dly_cnt_d  = '0;
          idx_d      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_p or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= S_WAIT_LOCK;
      lock_cnt_q <= '0;
      dly_cnt_q  <= '0;
      idx_q      <= '0;
      clk_en_q   <= 1'b0;
      rst_n_q    <= '0;
      done_q     <= 1'b0;
      loss_q     <= 8'd0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      idx_q      <= idx_d;
      clk_en_q   <= clk_en_d;
      rst_n_q    <= rst_n_d;
      done_q     <= done_d;
      loss_q     <= loss_d;
    end
  end

  assign clk_en        = clk_en_q;
  assign rst_n_out     = rst_n_q;
  assign seq_done      = done_q;
  assign lock_loss_cnt = loss_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: expected snapshots are queued with the
// edge they belong to and compared on the falling edge after that edge.
module tb_reset_seq_ctrl;

  logic       clk_p = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       clk_en;
  logic [2:0] rst_n_out;
  logic       seq_done;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_o;

  reset_seq_ctrl #(.NUM_STAGES(3), .STAGE_DELAY(16), .LOCK_FILTER(8)) dut (
    .clk_p        (clk_p),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .clk_en       (clk_en),
    .rst_n_out    (rst_n_out),
    .seq_done     (seq_done),
    .lock_loss_cnt(lock_loss_cnt),
    .state_o      (state_o)
  );

  always #5 clk_p = ~clk_p;

  typedef struct {
    int          cyc;
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk_p) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Snapshot layout: {state, clk_en, seq_done, rst_n_out, lock_loss_cnt}
  function automatic logic [15:0] mk(input logic [2:0] st, input logic ce, input logic sd,
                                     input logic [2:0] rn, input logic [7:0] lc);
    return {st, ce, sd, rn, lc};
  endfunction

  function automatic logic [15:0] obs();
    return {state_o, clk_en, seq_done, rst_n_out, lock_loss_cnt};
  endfunction

  task automatic push(input int c, input string tag, input logic [15:0] e);
    exp_t x;
    x.cyc = c;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  always @(negedge clk_p) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_x = sb_q.pop_front();
      check(mon_x.tag, {16'h0, obs()}, {16'h0, mon_x.exp});
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_p);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 8000) begin
      @(negedge clk_p);
      n++;
    end
    check("sb_drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, m, p, r, n, q, c0;
    reset_n      = 1'b0;
    pll_locked   = 1'b1;
    soft_rst_req = 1'b0;
    repeat (3) @(negedge clk_p);
    check("reset_state", {16'h0, obs()}, {16'h0, mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd0)});

    // Power-up with lock already present; edge 0 is three edges after release.
    reset_n = 1'b1;
    e0 = cyc + 3;
    push(e0 + 6,  "pu_pre_clken", mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd0));
    push(e0 + 7,  "pu_clken",     mk(3'd1, 1'b1, 1'b0, 3'b000, 8'd0));
    push(e0 + 22, "pu_clken_end", mk(3'd1, 1'b1, 1'b0, 3'b000, 8'd0));
    push(e0 + 23, "pu_release",   mk(3'd2, 1'b1, 1'b0, 3'b000, 8'd0));
    push(e0 + 38, "pu_pre_s0",    mk(3'd2, 1'b1, 1'b0, 3'b000, 8'd0));
    push(e0 + 39, "pu_s0",        mk(3'd2, 1'b1, 1'b0, 3'b001, 8'd0));
    push(e0 + 54, "pu_pre_s1",    mk(3'd2, 1'b1, 1'b0, 3'b001, 8'd0));
    push(e0 + 55, "pu_s1",        mk(3'd2, 1'b1, 1'b0, 3'b011, 8'd0));
    push(e0 + 70, "pu_pre_s2",    mk(3'd2, 1'b1, 1'b0, 3'b011, 8'd0));
    push(e0 + 71, "pu_run",       mk(3'd3, 1'b1, 1'b1, 3'b111, 8'd0));
    drain();

    // Soft reset from RUN.
    m = cyc;
    push(m + 1,  "soft_enter",   mk(3'd4, 1'b1, 1'b0, 3'b000, 8'd0));
    push(m + 16, "soft_hold",    mk(3'd4, 1'b1, 1'b0, 3'b000, 8'd0));
    push(m + 17, "soft_release", mk(3'd2, 1'b1, 1'b0, 3'b000, 8'd0));
    push(m + 33, "soft_s0",      mk(3'd2, 1'b1, 1'b0, 3'b001, 8'd0));
    push(m + 49, "soft_s1",      mk(3'd2, 1'b1, 1'b0, 3'b011, 8'd0));
    push(m + 64, "soft_pre_run", mk(3'd2, 1'b1, 1'b0, 3'b011, 8'd0));
    push(m + 65, "soft_run",     mk(3'd3, 1'b1, 1'b1, 3'b111, 8'd0));
    soft_rst_req = 1'b1;
    wait_until(m + 1);
    soft_rst_req = 1'b0;
    drain();

    // Lock lost in RELEASE at 011, with a soft request on the same edge.
    p = cyc;
    push(p + 49,  "ll_s1",        mk(3'd2, 1'b1, 1'b0, 3'b011, 8'd0));
    push(p + 52,  "ll_pre_loss",  mk(3'd2, 1'b1, 1'b0, 3'b011, 8'd0));
    push(p + 53,  "ll_loss_prio", mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd1));
    push(p + 64,  "ll_pre_relock",mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd1));
    push(p + 65,  "ll_relock",    mk(3'd1, 1'b1, 1'b0, 3'b000, 8'd1));
    push(p + 129, "ll_run",       mk(3'd3, 1'b1, 1'b1, 3'b111, 8'd1));
    soft_rst_req = 1'b1;
    wait_until(p + 1);
    soft_rst_req = 1'b0;
    wait_until(p + 50);
    pll_locked = 1'b0;
    wait_until(p + 52);
    soft_rst_req = 1'b1;
    wait_until(p + 53);
    soft_rst_req = 1'b0;
    wait_until(p + 55);
    pll_locked = 1'b1;
    drain();

    // Asynchronous reset mid-RUN clears every output without waiting for a clock.
    check("run_before_rst", {16'h0, obs()}, {16'h0, mk(3'd3, 1'b1, 1'b1, 3'b111, 8'd1)});
    #2;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    #1;
    check("async_rst", {16'h0, obs()}, {16'h0, mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd0)});
    repeat (3) @(negedge clk_p);
    reset_n = 1'b1;
    r = cyc;

    // Lock filter: 7 high, 1 low, then steady high; soft request ignored in CLK_EN.
    n = r + 4;
    push(n + 9,  "flt_no_early", mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd0));
    push(n + 10, "flt_glitch",   mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd0));
    push(n + 17, "flt_pre",      mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd0));
    push(n + 18, "flt_clken",    mk(3'd1, 1'b1, 1'b0, 3'b000, 8'd0));
    push(n + 21, "soft_ign",     mk(3'd1, 1'b1, 1'b0, 3'b000, 8'd0));
    push(n + 33, "flt_clk_end",  mk(3'd1, 1'b1, 1'b0, 3'b000, 8'd0));
    push(n + 34, "flt_release",  mk(3'd2, 1'b1, 1'b0, 3'b000, 8'd0));
    push(n + 82, "flt_run",      mk(3'd3, 1'b1, 1'b1, 3'b111, 8'd0));
    wait_until(n);
    pll_locked = 1'b1;
    wait_until(n + 7);
    pll_locked = 1'b0;
    wait_until(n + 8);
    pll_locked = 1'b1;
    wait_until(n + 20);
    soft_rst_req = 1'b1;
    wait_until(n + 21);
    soft_rst_req = 1'b0;
    drain();

    // 300 lock losses: one from RUN, then 299 short lock/unlock cycles.
    q  = cyc;
    c0 = q + 5;
    push(q + 3, "sat_first", mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd1));
    push(c0 + 16 * 252 + 14, "sat_254",     mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd254));
    push(c0 + 16 * 253 + 13, "sat_pre_255", mk(3'd1, 1'b1, 1'b0, 3'b000, 8'd254));
    push(c0 + 16 * 253 + 14, "sat_255",     mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd255));
    push(c0 + 16 * 298 + 13, "sat_pre_end", mk(3'd1, 1'b1, 1'b0, 3'b000, 8'd255));
    push(c0 + 16 * 298 + 14, "sat_hold",    mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd255));
    pll_locked = 1'b0;
    for (int k = 0; k < 299; k++) begin
      wait_until(c0 + 16 * k);
      pll_locked = 1'b1;
      wait_until(c0 + 16 * k + 11);
      pll_locked = 1'b0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of sequenced downstream reset domains (1..8).
REQ-002 SHALL have parameter STAGE_DELAY, default 16, clocks between successive sequencing steps (>=2).
REQ-003 SHALL have parameter LOCK_FILTER, default 8, consecutive pll_locked-high clocks required before enabling clocks (>=1).
REQ-004 SHALL have port clk_p, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port pll_locked, input, 1 bit: clock-source lock status, asynchronous to clk_p.
REQ-007 SHALL have port soft_rst_req, input, 1 bit: single-cycle request to re-run reset release.
REQ-008 SHALL have port clk_en, output, 1 bit: downstream clock enable.
REQ-009 SHALL have port rst_n_out, output, NUM_STAGES bits: per-domain active-low resets; bit 0 is released first.
REQ-010 SHALL have port seq_done, output, 1 bit: all domains out of reset.
REQ-011 SHALL have port lock_loss_cnt, output, 8 bits: saturating count of lock losses.
REQ-012 SHALL have port state_o, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-013 SHALL pass reset_n through a 2-flop synchronizer: assertion asynchronous, deassertion after 2 clk_p edges; internal logic uses the synchronized reset.
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer; all references below mean the synchronized value.
REQ-015 SHALL register all outputs; an output change takes effect on the same edge as the FSM transition causing it.
REQ-016 SHALL implement the states WAIT_LOCK=0, CLK_EN=1, RELEASE=2, RUN=3, SOFT=4; other encodings SHALL go to WAIT_LOCK.
REQ-017 In WAIT_LOCK, the lock counter SHALL increment while locked=1 and clear when locked=0; at the edge where counter==LOCK_FILTER-1 and locked=1, the FSM SHALL go to CLK_EN and set clk_en=1.
REQ-018 In CLK_EN, the delay counter SHALL count STAGE_DELAY edges; on the last edge the FSM SHALL go to RELEASE with stage index 0 and a cleared counter.
REQ-019 In RELEASE, each STAGE_DELAY-th edge SHALL set rst_n_out[idx]=1; if idx==NUM_STAGES-1 the FSM SHALL go to RUN and set seq_done=1 on that same edge, otherwise idx SHALL increment.
REQ-020 In RUN, the outputs SHALL hold with seq_done=1.
REQ-021 On soft_rst_req=1 in RELEASE or RUN, the FSM SHALL go to SOFT, drive rst_n_out to all zeros, set seq_done=0 and hold clk_en=1 on the next edge.
REQ-022 soft_rst_req SHALL be ignored in WAIT_LOCK, CLK_EN and SOFT.
REQ-023 SOFT SHALL hold STAGE_DELAY edges, then go to RELEASE with idx=0; the release then repeats as REQ-019.
REQ-024 In any state except WAIT_LOCK, locked=0 SHALL on the next edge force clk_en=0, rst_n_out=0, seq_done=0, clear the counters and go to WAIT_LOCK.
REQ-025 A lock loss under REQ-024 SHALL increment lock_loss_cnt, saturating at 255.
REQ-026 Lock loss SHALL take priority over soft_rst_req on the same edge.
REQ-027 Counter widths SHALL be sized by $clog2 of the parameter, with no wrap before the terminal compare.

Reset
REQ-028 While synchronized reset is low, the outputs SHALL be: clk_en=0, rst_n_out=all 0, seq_done=0, lock_loss_cnt=0, state_o=WAIT_LOCK; the counters and idx SHALL be 0.
REQ-029 reset_n asserted mid-sequence SHALL return all outputs to REQ-028 values asynchronously, with no glitch-high on any rst_n_out bit.

Verification (defaults; edge 0 = first edge with synchronized reset and lock both high)
REQ-030 Power-up with pll_locked=1 -> clk_en rises after edge 7; rst_n_out goes 001 after edge 39, 011 after edge 55, 111 after edge 71; seq_done=1 after edge 71.
REQ-031 pll_locked held 7 cycles, low 1, then high -> no clk_en until 8 consecutive high cycles; lock counter restarts.
REQ-032 In RUN, pulse soft_rst_req -> rst_n_out=000 and seq_done=0 next edge, clk_en stays 1; 16 edges later RELEASE; 111 after 48 more edges.
REQ-033 In RELEASE with rst_n_out=011, drop pll_locked -> clk_en=0, rst_n_out=000 and lock_loss_cnt=1 two sync edges +1 later; sequence restarts on relock.
REQ-034 Same edge: soft_rst_req=1 and lock lost -> state WAIT_LOCK, not SOFT.
REQ-035 300 lock-loss events -> lock_loss_cnt=255; reset_n pulse low mid-RUN -> all outputs 0 immediately.
